// File: rtl/out_port_alloc_pkg.sv
// Shared router definitions for the output-port allocator: FSM state
// encoding and default flit geometry.
package out_port_alloc_pkg;

  // Default number of input ports competing for one output.
  localparam int unsigned ALLOC_IN_N = 5;

  // Default flit payload width.
  localparam int unsigned FLIT_DATA_W = 32;

  // Port ownership state: IDLE arbitrates, LOCKED streams one packet.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

endpackage : out_port_alloc_pkg

// File: rtl/out_port_alloc_if.sv
// Bundle of all flit-path signals around one output port: the input-buffer
// side (per-input valid/last/data and pop) and the output-link side.
//
// Handshake rules, both sides:
//   - A flit moves on a cycle where valid and ready are both high at the
//     rising clock edge. valid never depends on ready.
//   - Upstream: in_rdy_o is the pop for input k; at most one bit is high,
//     and only for the current owner while the port is locked.
//   - Downstream: out_vld_o/out_last_o/out_data_o come from a register and
//     hold steady while out_vld_o=1 and out_rdy_i=0.
interface out_port_alloc_if
  import out_port_alloc_pkg::*;
#(
  parameter int IN_N       = ALLOC_IN_N,
  parameter int DATA_WIDTH = FLIT_DATA_W
) ();

  localparam int SEL_W = $clog2(IN_N);

  logic [IN_N-1:0]            in_vld_i;
  logic [IN_N-1:0]            in_last_i;
  logic [IN_N*DATA_WIDTH-1:0] in_data_i;
  logic [IN_N-1:0]            in_rdy_o;
  logic                       out_vld_o;
  logic                       out_last_o;
  logic [DATA_WIDTH-1:0]      out_data_o;
  logic                       out_rdy_i;
  logic [SEL_W-1:0]           sel_o;
  logic                       locked_o;

  // Allocator side.
  modport master (
    input  in_vld_i, in_last_i, in_data_i, out_rdy_i,
    output in_rdy_o, out_vld_o, out_last_o, out_data_o, sel_o, locked_o
  );

  // Environment side: input buffers plus downstream link.
  modport slave (
    output in_vld_i, in_last_i, in_data_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, out_last_o, out_data_o, sel_o, locked_o
  );

endinterface : out_port_alloc_if

// File: rtl/out_port_alloc_arb.sv
// Round-robin matrix arbiter. prio_q[i][j]=1 means requester i beats j.
// A granted requester drops to lowest priority when upd_i is high, which
// gives strong fairness: every waiting requester is served within N grants.
module rr_matrix_arb
  import out_port_alloc_pkg::*;
#(
  parameter int N = ALLOC_IN_N,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             upd_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  // Diagonal stays 0 so it never blocks a requester against itself.
  logic [N-1:0] prio_q [N];
  logic [N-1:0] beaten_c;

  // Grant the active requester that no other active requester beats.
  always_comb begin
    beaten_c  = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        beaten_c[j] = beaten_c[j] | (req_i[i] & prio_q[i][j]);
      end
      gnt_o[j] = req_i[j] & ~beaten_c[j];
    end
    for (int j = 0; j < N; j++) begin
      if (gnt_o[j]) gnt_idx_o = gnt_idx_o | IDX_W'(j);
    end
  end

  // Priority matrix: reset to index order, winner moves to lowest priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          prio_q[i][j] <= (i < j);
        end
      end
    end else if (upd_i && (|gnt_o)) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i != j) begin
            if (gnt_o[i])      prio_q[i][j] <= 1'b0;
            else if (gnt_o[j]) prio_q[i][j] <= 1'b1;
          end
        end
      end
    end
  end

endmodule : rr_matrix_arb

// File: rtl/out_port_alloc.sv
// Wormhole output-port allocator and output stage. In IDLE the matrix
// arbiter picks a head flit; the winner then owns the port until its tail
// flit has been loaded into the output register. Flits from the owner are
// muxed and registered toward the link.
module out_port_alloc
  import out_port_alloc_pkg::*;
#(
  parameter int IN_N       = ALLOC_IN_N,
  parameter int DATA_WIDTH = FLIT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  out_port_alloc_if.master  bus,
  output alloc_state_e      state_o
);

  localparam int SEL_W = $clog2(IN_N);

  alloc_state_e          state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  out_vld_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [IN_N-1:0]       arb_gnt;
  logic [SEL_W-1:0]      arb_gnt_idx;
  logic                  arb_upd;

  logic                  own_vld;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  accept;
  logic                  xfer;
  logic [IN_N-1:0]       in_rdy_c;

  rr_matrix_arb #(
    .N (IN_N)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (bus.in_vld_i),
    .upd_i     (arb_upd),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_gnt_idx)
  );

  // Crossbar mux: pick the current owner's valid/last/data.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int k = 0; k < IN_N; k++) begin
      if (sel_q == SEL_W'(k)) begin
        own_vld  = bus.in_vld_i[k];
        own_last = bus.in_last_i[k];
        own_data = bus.in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The output register can take a flit when empty or draining this cycle.
  assign accept = ~out_vld_q | bus.out_rdy_i;

  // Next-state, owner select, pop and matrix update.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    arb_upd  = 1'b0;
    in_rdy_c = '0;
    xfer     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // No flit is popped while arbitrating; the head waits for lock.
        if (|arb_gnt) begin
          arb_upd = 1'b1;
          sel_d   = arb_gnt_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        in_rdy_c = IN_N'(accept) << sel_q;
        xfer     = own_vld & accept;
        if (xfer && own_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and owner index.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Output register: load on transfer, clear valid once drained.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else if (xfer) begin
      out_vld_q  <= 1'b1;
      out_last_q <= own_last;
      out_data_q <= own_data;
    end else if (bus.out_rdy_i) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign bus.in_rdy_o   = in_rdy_c;
  assign bus.out_vld_o  = out_vld_q;
  assign bus.out_last_o = out_last_q;
  assign bus.out_data_o = out_data_q;
  assign bus.sel_o      = sel_q;
  assign bus.locked_o   = (state_q == ST_LOCKED);
  assign state_o        = state_q;

endmodule : out_port_alloc

// File: tb/tb_out_port_alloc.sv
// Directed bench for out_port_alloc: packet sources per input, an output
// scoreboard fed at pop time, and one task per scenario.
module tb_out_port_alloc;
  import out_port_alloc_pkg::*;

  localparam int IN_N = 5;
  localparam int DW   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  out_port_alloc_if #(.IN_N(IN_N), .DATA_WIDTH(DW)) bus ();
  alloc_state_e state;

  out_port_alloc #(.IN_N(IN_N), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0] exp_q[$];   // {last, data} in pop order
  int owner_q[$];          // sel_o value at each new lock
  logic prev_locked = 1'b0;
  int out_src = 0;
  bit out_mid = 1'b0;

  // Packet sources, one per input.
  bit s_act  [IN_N];
  bit s_hold [IN_N];
  int s_len  [IN_N];
  int s_flit [IN_N];
  int s_pkt  [IN_N];
  int s_npkt [IN_N];

  function automatic logic [DW-1:0] flit_data(int k, int p, int f);
    return {4'hA, 4'(k), 8'(p), 16'(f)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_srcs();
    for (int k = 0; k < IN_N; k++) begin
      bus.in_vld_i[k]  = s_act[k] && (s_npkt[k] > 0) && !s_hold[k];
      bus.in_last_i[k] = (s_flit[k] == s_len[k] - 1);
      bus.in_data_i[k*DW +: DW] = flit_data(k, s_pkt[k], s_flit[k]);
    end
  endtask

  task automatic src_clear();
    for (int k = 0; k < IN_N; k++) begin
      s_act[k] = 0; s_hold[k] = 0; s_len[k] = 1;
      s_flit[k] = 0; s_pkt[k] = 0; s_npkt[k] = 0;
    end
    exp_q.delete();
    owner_q.delete();
    out_mid = 1'b0;
    drive_srcs();
  endtask

  task automatic src_start(int k, int len, int npkt);
    s_act[k] = 1; s_len[k] = len; s_npkt[k] = npkt; s_flit[k] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.out_rdy_i = 1'b1;
    src_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    prev_locked = 1'b0;
    #1;
  endtask

  // One clock: sample at negedge (scoreboard + pops), advance sources after
  // the rising edge, return with inputs driven and outputs settled.
  task automatic tick();
    logic [IN_N-1:0] pop;
    logic [IN_N-1:0] mask;
    logic [DW:0] got, e;
    @(negedge clk);
    pop  = bus.in_vld_i & bus.in_rdy_o;
    mask = bus.locked_o ? (IN_N'(1) << bus.sel_o) : '0;
    n_checks++;
    if ((bus.in_rdy_o & ~mask) != '0) begin
      n_errors++;
      $display("FAIL in_rdy_owner: got %b allowed %b", bus.in_rdy_o, mask);
    end
    if (bus.out_vld_o && bus.out_rdy_i) begin
      got = {bus.out_last_o, bus.out_data_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL out_unexpected: got %h expected nothing", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_errors++;
          $display("FAIL out_flit: got %h expected %h", got, e);
        end
      end
      n_checks++;
      if (out_mid && (int'(bus.out_data_o[27:24]) != out_src)) begin
        n_errors++;
        $display("FAIL interleave: got src %0d expected src %0d",
                 bus.out_data_o[27:24], out_src);
      end
      out_src = int'(bus.out_data_o[27:24]);
      out_mid = !bus.out_last_o;
    end
    for (int k = 0; k < IN_N; k++) begin
      if (pop[k]) exp_q.push_back({s_flit[k] == s_len[k] - 1,
                                   flit_data(k, s_pkt[k], s_flit[k])});
    end
    @(posedge clk); #1;
    for (int k = 0; k < IN_N; k++) begin
      if (pop[k]) begin
        if (s_flit[k] == s_len[k] - 1) begin
          s_flit[k] = 0; s_pkt[k]++; s_npkt[k]--;
        end else begin
          s_flit[k]++;
        end
      end
    end
    drive_srcs();
    #1;
    if (bus.locked_o && !prev_locked) owner_q.push_back(int'(bus.sel_o));
    prev_locked = bus.locked_o;
  endtask

  function automatic bit all_done();
    bit d = !bus.out_vld_o && (exp_q.size() == 0);
    for (int k = 0; k < IN_N; k++) if (s_act[k] && s_npkt[k] > 0) d = 0;
    return d;
  endfunction

  task automatic run_until_done(int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      if (all_done()) begin ok = 1; break; end
      tick();
    end
    if (all_done()) ok = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.out_rdy_i = 1'b1;
    src_clear();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.out_vld_o !== 1'b0) begin n_errors++; $display("FAIL rst_out_vld: got %b expected 0", bus.out_vld_o); end
    n_checks++; if (bus.out_last_o !== 1'b0) begin n_errors++; $display("FAIL rst_out_last: got %b expected 0", bus.out_last_o); end
    n_checks++; if (bus.out_data_o !== '0) begin n_errors++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data_o); end
    n_checks++; if (bus.sel_o !== '0) begin n_errors++; $display("FAIL rst_sel: got %0d expected 0", bus.sel_o); end
    n_checks++; if (bus.locked_o !== 1'b0) begin n_errors++; $display("FAIL rst_locked: got %b expected 0", bus.locked_o); end
    n_checks++; if (bus.in_rdy_o !== '0) begin n_errors++; $display("FAIL rst_in_rdy: got %b expected 0", bus.in_rdy_o); end
    n_checks++; if (state !== ST_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d expected IDLE", state); end
    rst = 1'b0;
    prev_locked = 1'b0;
    tick();
    n_checks++; if (bus.locked_o !== 1'b0) begin n_errors++; $display("FAIL idle_no_req: got locked %b expected 0", bus.locked_o); end
  endtask

  task automatic test_two_single();
    bit ok;
    do_reset();
    src_start(1, 1, 1);
    src_start(2, 1, 1);
    drive_srcs(); #1;
    n_checks++; if (bus.in_rdy_o !== 5'b00000) begin n_errors++; $display("FAIL idle_in_rdy: got %b expected 00000", bus.in_rdy_o); end
    tick();
    n_checks++; if (bus.locked_o !== 1'b1 || bus.sel_o !== 3'd1) begin n_errors++; $display("FAIL two_lock1: got locked %b sel %0d expected 1 sel 1", bus.locked_o, bus.sel_o); end
    n_checks++; if (bus.in_rdy_o !== 5'b00010) begin n_errors++; $display("FAIL two_rdy1: got %b expected 00010", bus.in_rdy_o); end
    tick();
    n_checks++; if (bus.out_vld_o !== 1'b1 || bus.out_last_o !== 1'b1 || bus.out_data_o !== 32'hA1000000) begin n_errors++; $display("FAIL two_out1: got vld %b last %b data %h expected 1 1 a1000000", bus.out_vld_o, bus.out_last_o, bus.out_data_o); end
    n_checks++; if (bus.locked_o !== 1'b0) begin n_errors++; $display("FAIL two_unlock1: got %b expected 0", bus.locked_o); end
    tick();
    n_checks++; if (bus.locked_o !== 1'b1 || bus.sel_o !== 3'd2) begin n_errors++; $display("FAIL two_lock2: got locked %b sel %0d expected 1 sel 2", bus.locked_o, bus.sel_o); end
    tick();
    n_checks++; if (bus.out_vld_o !== 1'b1 || bus.out_data_o !== 32'hA2000000) begin n_errors++; $display("FAIL two_out2: got vld %b data %h expected 1 a2000000", bus.out_vld_o, bus.out_data_o); end
    run_until_done(20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL two_timeout: got busy expected drained"); end
    n_checks++; if (owner_q.size() != 2 || owner_q[0] != 1 || owner_q[1] != 2) begin n_errors++; $display("FAIL two_order: got %p expected '{1,2}", owner_q); end
  endtask

  task automatic test_all_five();
    int exp_own [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    bit ok;
    do_reset();
    for (int k = 0; k < IN_N; k++) src_start(k, 3, 2);
    drive_srcs(); #1;
    run_until_done(150, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL five_timeout: got busy expected drained"); end
    n_checks++; if (owner_q.size() != 10) begin n_errors++; $display("FAIL five_count: got %0d expected 10", owner_q.size()); end
    for (int i = 0; i < 10 && i < owner_q.size(); i++) begin
      n_checks++;
      if (owner_q[i] != exp_own[i]) begin n_errors++; $display("FAIL five_order[%0d]: got %0d expected %0d", i, owner_q[i], exp_own[i]); end
    end
  endtask

  task automatic test_owner_stall();
    bit ok;
    do_reset();
    src_start(0, 4, 1);
    src_start(3, 2, 1);
    drive_srcs(); #1;
    tick();
    n_checks++; if (bus.sel_o !== 3'd0 || bus.locked_o !== 1'b1) begin n_errors++; $display("FAIL stall_lock: got sel %0d locked %b expected 0 1", bus.sel_o, bus.locked_o); end
    tick();
    n_checks++; if (bus.out_vld_o !== 1'b1 || bus.out_data_o !== 32'hA0000000) begin n_errors++; $display("FAIL stall_head: got vld %b data %h expected 1 a0000000", bus.out_vld_o, bus.out_data_o); end
    s_hold[0] = 1;
    drive_srcs(); #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.out_vld_o !== 1'b0) begin n_errors++; $display("FAIL stall_idle[%0d]: got out_vld %b expected 0", i, bus.out_vld_o); end
      n_checks++; if (bus.in_rdy_o !== 5'b00001 || bus.locked_o !== 1'b1) begin n_errors++; $display("FAIL stall_rdy[%0d]: got rdy %b locked %b expected 00001 1", i, bus.in_rdy_o, bus.locked_o); end
    end
    s_hold[0] = 0;
    drive_srcs(); #1;
    run_until_done(40, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL stall_timeout: got busy expected drained"); end
    n_checks++; if (owner_q.size() != 2 || owner_q[0] != 0 || owner_q[1] != 3) begin n_errors++; $display("FAIL stall_order: got %p expected '{0,3}", owner_q); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    src_start(2, 6, 1);
    drive_srcs(); #1;
    repeat (3) tick();
    n_checks++; if (bus.out_data_o !== 32'hA2000001) begin n_errors++; $display("FAIL bp_pre: got %h expected a2000001", bus.out_data_o); end
    bus.out_rdy_i = 1'b0; #1;
    n_checks++; if (bus.in_rdy_o !== 5'b00000) begin n_errors++; $display("FAIL bp_rdy_now: got %b expected 00000", bus.in_rdy_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.out_vld_o !== 1'b1 || bus.out_data_o !== 32'hA2000001) begin n_errors++; $display("FAIL bp_hold[%0d]: got vld %b data %h expected 1 a2000001", i, bus.out_vld_o, bus.out_data_o); end
      n_checks++; if (bus.in_rdy_o !== 5'b00000) begin n_errors++; $display("FAIL bp_rdy[%0d]: got %b expected 00000", i, bus.in_rdy_o); end
    end
    bus.out_rdy_i = 1'b1; #1;
    run_until_done(30, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_timeout: got busy expected drained"); end
    n_checks++; if (s_pkt[2] != 1) begin n_errors++; $display("FAIL bp_popped: got %0d packets expected 1", s_pkt[2]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    src_start(4, 5, 1);
    drive_srcs(); #1;
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.out_vld_o !== 1'b0 || bus.out_last_o !== 1'b0 || bus.out_data_o !== '0) begin n_errors++; $display("FAIL mid_out: got vld %b last %b data %h expected 0 0 0", bus.out_vld_o, bus.out_last_o, bus.out_data_o); end
    n_checks++; if (bus.sel_o !== '0 || bus.locked_o !== 1'b0 || bus.in_rdy_o !== '0) begin n_errors++; $display("FAIL mid_ctl: got sel %0d locked %b rdy %b expected 0 0 0", bus.sel_o, bus.locked_o, bus.in_rdy_o); end
    n_checks++; if (state !== ST_IDLE) begin n_errors++; $display("FAIL mid_state: got %0d expected IDLE", state); end
    src_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    prev_locked = 1'b0;
    src_start(0, 1, 1);
    src_start(4, 1, 1);
    drive_srcs(); #1;
    tick();
    n_checks++; if (bus.locked_o !== 1'b1 || bus.sel_o !== 3'd0) begin n_errors++; $display("FAIL mid_win: got locked %b sel %0d expected 1 sel 0", bus.locked_o, bus.sel_o); end
    run_until_done(20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL mid_timeout: got busy expected drained"); end
    n_checks++; if (owner_q.size() != 2 || owner_q[0] != 0 || owner_q[1] != 4) begin n_errors++; $display("FAIL mid_order: got %p expected '{0,4}", owner_q); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    src_start(1, 1, 3);
    drive_srcs(); #1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (bus.out_vld_o !== 1'(c % 2) || bus.locked_o !== 1'((c + 1) % 2)) begin
        n_errors++;
        $display("FAIL b2b_cycle[%0d]: got vld %b locked %b expected %0d %0d", c, bus.out_vld_o, bus.locked_o, c % 2, (c + 1) % 2);
      end
      if (c % 2 == 1) begin
        n_checks++;
        if (bus.out_data_o !== flit_data(1, c / 2, 0)) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", c, bus.out_data_o, flit_data(1, c / 2, 0)); end
      end
    end
    run_until_done(10, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL b2b_timeout: got busy expected drained"); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.out_rdy_i = 1'b1;
    src_clear();
    test_reset();
    test_two_single();
    test_all_five();
    test_owner_stall();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_out_port_alloc
